serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial WIDTH-bit adder with carry-in; it is the sequential adder counterpart of the team's ripple-carry subtractor. Each cycle it consumes one bit pair, LSB first, through a single full-adder cell. The result is presented with a start/busy/done handshake. It sits in the arithmetic block set where area matters more than latency, and shares the a/b/c/s/co operand convention with the existing subtractor.

## Interface
- WIDTH, 4, operand and result width in bits; legal range ≥ 2.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only when idle or done.
- a  input  WIDTH  addend, sampled on the accepting edge.
- b  input  WIDTH  addend, sampled on the accepting edge.
- c  input  1  carry-in, sampled on the accepting edge.
- s  output  WIDTH  sum; registered, holds until the next completion.
- co  output  1  carry-out; registered, holds until the next completion.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when s/co are newly valid.

## Operation
- States: IDLE, SHIFT, DONE. busy = (state == SHIFT). done = (state == DONE).
- IDLE:
  - start = 1 → latch a into shift register A, b into shift register B, c into carry; clear the bit counter; go to SHIFT.
  - start = 0 → stay in IDLE.
- SHIFT, every cycle:
  - sum bit = A[0] ^ B[0] ^ carry.
  - carry ← majority(A[0], B[0], carry).
  - Shift the sum bit into the MSB of the result shift register.
  - Shift A and B right by one.
  - Increment the counter.
  - On the cycle the counter reaches WIDTH-1: load s from the completed result register and co from the final carry; go to DONE.
- DONE, one cycle only:
  - start = 1 → accept new operands exactly as in IDLE and go to SHIFT (back-to-back operation).
  - start = 0 → go to IDLE.
- start during SHIFT is ignored. It is neither queued nor corrupting.
- a, b and c may change freely after the accepting edge.
- Arithmetic: {co, s} = a + b + c, modulo 2^(WIDTH+1). The operands are unsigned; no overflow flag.
- Counter width is $clog2(WIDTH). It must not wrap before the DONE transition.

## Timing
- Reset values:
  - state = IDLE; busy = 0; done = 0.
  - s = 0; co = 0.
  - Internal shift registers, carry and counter = 0.
- Reset has priority over start on the same edge.
- Reset mid-SHIFT aborts the operation. s and co return to 0 and no done pulse is produced.
- Latency: if start is accepted at edge k, then:
  - busy is high in cycles k+1 … k+WIDTH.
  - done is high, and s/co show the new result, in cycle k+WIDTH+1.
- Throughput: one result per WIDTH+1 cycles with back-to-back start in DONE.
- After a back-to-back start, s/co keep the previous result until the next DONE.

## Structure
- Package serial_adder_pkg holds:
  - the state enum typedef (IDLE, SHIFT, DONE);
  - the state width constant.
- One sub-module: full_adder_bit. It is purely combinational, with inputs x, y, cin and outputs sum, cout, and is instantiated once for the serial datapath.
- The FSM, shift registers and counter live in serial_adder.

## Test plan
- Reset, then a=0001, b=0011, c=0, start pulsed one cycle:
  - busy is high for 4 cycles;
  - done pulses in cycle 5 after the accepting edge;
  - s=0100, co=0.
- a=1101, b=0011, c=0 → s=0000, co=1.
- a=1001, b=0011, c=1 → s=1101, co=0.
- a=1111, b=1101, c=1 → s=1101, co=1.
- start re-pulsed with different operands during SHIFT → ignored; the first result is unchanged and there is exactly one done pulse.
- Back-to-back and reset cases:
  - start held during DONE → the new op starts immediately, busy rises the next cycle, and s holds the old value until the second done.
  - rst asserted mid-SHIFT → s=0, co=0, busy=0 on the next cycle, and no done pulse.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and its width.
package serial_adder_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// Single combinational full-adder cell used as the serial datapath.
module full_adder_bit (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with carry-in; one bit pair per cycle, LSB first,
// with a start/busy/done handshake and registered s/co.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] res_reg, res_next;
    logic [WIDTH-1:0] s_reg, s_next;
    logic             carry_reg, carry_next;
    logic             co_reg, co_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic             sum_bit;
    logic             carry_out;
    logic [WIDTH-1:0] res_shifted;

    full_adder_bit u_full_adder_bit (
        .x    (a_reg[0]),
        .y    (b_reg[0]),
        .cin  (carry_reg),
        .sum  (sum_bit),
        .cout (carry_out)
    );

    // Result register fills from the MSB so the final bit lands it aligned.
    assign res_shifted = {sum_bit, res_reg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            s_reg     <= '0;
            carry_reg <= 1'b0;
            co_reg    <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            res_reg   <= res_next;
            s_reg     <= s_next;
            carry_reg <= carry_next;
            co_reg    <= co_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        res_next   = res_reg;
        s_next     = s_reg;
        carry_next = carry_reg;
        co_next    = co_reg;
        cnt_next   = cnt_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    a_next     = a;
                    b_next     = b;
                    carry_next = c;
                    res_next   = '0;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                carry_next = carry_out;
                res_next   = res_shifted;
                a_next     = a_reg >> 1;
                b_next     = b_reg >> 1;
                cnt_next   = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_LAST) begin
                    s_next     = res_shifted;
                    co_next    = carry_out;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign s    = s_reg;
    assign co   = co_reg;
    assign busy = (state_reg == SHIFT);
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder (WIDTH=4) with hand-computed sums.
module tb_serial_adder;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] s;
    logic         co;
    logic         busy;
    logic         done;

    int vectors;
    int miscompares;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c     (c),
        .s     (s),
        .co    (co),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle, then follow busy/done/s/co through the op.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input logic [W-1:0] old_s, input logic old_co,
                          input logic [W-1:0] exp_s, input logic exp_co);
        @(negedge clk);
        a = av; b = bv; c = cv; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; a = '0; b = '0; c = 1'b0;
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            check({tag, "_hold"}, 32'({old_co, old_s}), 32'({co, s}));
        end
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_lo"}, 32'(busy), 32'd0);
        check({tag, "_s"}, 32'(s), 32'(exp_s));
        check({tag, "_co"}, 32'(co), 32'(exp_co));
        @(negedge clk);
        check({tag, "_done_lo"}, 32'(done), 32'd0);
        check({tag, "_s_kept"}, 32'(s), 32'(exp_s));
        $display("op %s: a=%b b=%b c=%b -> s=%b co=%b", tag, av, bv, cv, s, co);
    endtask

    initial begin
        int done_cnt;
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; start = 1'b1; a = 4'b1111; b = 4'b1111; c = 1'b1;

        // Reset wins over a simultaneous start.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_co", 32'(co), 32'd0);
        rst = 1'b0; start = 1'b0; a = '0; b = '0; c = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        $display("reset: busy=%b done=%b s=%b co=%b", busy, done, s, co);

        run_op("v1", 4'b0001, 4'b0011, 1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0);
        run_op("v2", 4'b1101, 4'b0011, 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1);
        run_op("v3", 4'b1001, 4'b0011, 1'b1, 4'b0000, 1'b1, 4'b1101, 1'b0);
        run_op("v4", 4'b1111, 4'b1101, 1'b1, 4'b1101, 1'b0, 4'b1101, 1'b1);

        // start during SHIFT is ignored: 2+3 = 5, not 7+7+1.
        @(negedge clk);
        a = 4'b0010; b = 4'b0011; c = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 2) begin
                a = 4'b0111; b = 4'b0111; c = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_cnt++;
                check("ign_s", 32'(s), 32'd5);
                check("ign_co", 32'(co), 32'd0);
                check("ign_when", 32'(i), 32'(W + 1));
            end
        end
        check("ign_done_cnt", 32'(done_cnt), 32'd1);
        $display("ignore-start: done pulses=%0d s=%b co=%b", done_cnt, s, co);

        // Back-to-back: 1+1 = 2, then start held in DONE for 4+5+1 = 10.
        @(negedge clk);
        a = 4'b0001; b = 4'b0001; c = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= W; i++) @(negedge clk);
        a = 4'b0100; b = 4'b0101; c = 1'b1; start = 1'b1;
        @(negedge clk);
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_s1", 32'(s), 32'd2);
        @(posedge clk);
        #1 start = 1'b0; a = '0; b = '0; c = 1'b0;
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            check("b2b_busy", 32'(busy), 32'd1);
            check("b2b_hold", 32'(s), 32'd2);
        end
        @(negedge clk);
        check("b2b_done2", 32'(done), 32'd1);
        check("b2b_s2", 32'(s), 32'd10);
        check("b2b_co2", 32'(co), 32'd0);
        $display("back-to-back: s=%b co=%b", s, co);

        // Reset mid-SHIFT aborts with no done pulse.
        @(negedge clk);
        a = 4'b1111; b = 4'b1111; c = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_s", 32'(s), 32'd0);
        check("abort_co", 32'(co), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("abort_nodone", 32'(done_cnt), 32'd0);
        $display("abort: s=%b co=%b busy=%b done pulses=%0d", s, co, busy, done_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
